mult_div_unit: RTL and testbench

Iterative multiply/divide unit for the MIPS datapath, directly downstream of the register file read ports. It takes the two read-port operands (rs, rt) and executes MULT/MULTU/DIV/DIVU over 33 cycles into private HI/LO registers, plus single-cycle MTHI/MTLO. HI/LO feed the MFHI/MFLO path back to the register file write port. The control unit stalls on `busy`.

---
 rtl/mult_div_unit_if.sv | 22 ++
 rtl/mult_div_unit.sv | 125 ++++++++++++
 tb/tb_mult_div_unit.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mult_div_unit_if.sv
// mult_div_unit_if: request/result bundle of the multiply/divide unit.
// master drives start/op/a/b; slave returns busy/done/hi/lo.
interface mult_div_unit_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, a, b,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mult_div_unit.sv
// mult_div_unit: 33-cycle iterative MULT/MULTU/DIV/DIVU into HI/LO, 1-cycle MTHI/MTLO.
// Ports: clk, rst (async, active-high), bus (slave: start/op/a/b in, busy/done/hi/lo out).
module mult_div_unit (
  input  logic            clk,
  input  logic            rst,
  mult_div_unit_if.slave  bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  localparam logic [2:0] OP_MTHI = 3'b100;
  localparam logic [2:0] OP_MTLO = 3'b101;

  logic [1:0]  r_state;
  logic [4:0]  r_cnt;
  logic [63:0] r_acc;
  logic [31:0] r_opnd;
  logic        r_div;
  logic        r_neg_q;
  logic        r_neg_r;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic        r_done;

  logic        w_signed;
  logic        w_muldiv;
  logic [31:0] w_abs_a;
  logic [31:0] w_abs_b;
  logic [32:0] w_madd;
  logic [63:0] w_mul_next;
  logic [32:0] w_rem;
  logic [33:0] w_diff;
  logic        w_ge;
  logic [63:0] w_div_next;
  logic [63:0] w_prod;
  logic [31:0] w_quo;
  logic [31:0] w_rmd;

  assign w_signed = bus.op[0];
  assign w_muldiv = ~bus.op[2];
  assign w_abs_a  = (w_signed && bus.a[31]) ? -bus.a : bus.a;
  assign w_abs_b  = (w_signed && bus.b[31]) ? -bus.b : bus.b;

  // Shift-add: multiplier sits in acc[31:0], partial product grows from the top.
  assign w_madd     = {1'b0, r_acc[63:32]}
                    + {1'b0, (r_acc[0] ? r_opnd : 32'd0)};
  assign w_mul_next = {w_madd, r_acc[31:1]};

  // Restoring divide: remainder in acc[63:32], dividend shifts out of acc[31:0]
  // while quotient bits shift in.
  assign w_rem      = {r_acc[63:32], r_acc[31]};
  assign w_diff     = {1'b0, w_rem} - {2'b00, r_opnd};
  assign w_ge       = ~w_diff[33];
  assign w_div_next = {(w_ge ? w_diff[31:0] : w_rem[31:0]),
                       r_acc[30:0], w_ge};

  // A zero divisor yields all-ones quotient; keep it unnegated.
  assign w_prod = r_neg_q ? -r_acc : r_acc;
  assign w_quo  = (r_neg_q && (r_opnd != 32'd0)) ? -r_acc[31:0]
                                                 : r_acc[31:0];
  assign w_rmd  = r_neg_r ? -r_acc[63:32] : r_acc[63:32];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 5'd0;
      r_acc   <= 64'd0;
      r_opnd  <= 32'd0;
      r_div   <= 1'b0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            if (w_muldiv) begin
              r_state <= S_RUN;
              r_cnt   <= 5'd0;
              r_div   <= bus.op[1];
              r_neg_q <= w_signed & (bus.a[31] ^ bus.b[31]);
              r_neg_r <= w_signed & bus.a[31];
              r_opnd  <= bus.op[1] ? w_abs_b : w_abs_a;
              r_acc   <= {32'd0, (bus.op[1] ? w_abs_a : w_abs_b)};
            end else if (bus.op == OP_MTHI) begin
              r_hi <= bus.a;
            end else if (bus.op == OP_MTLO) begin
              r_lo <= bus.a;
            end
          end
        end
        S_RUN: begin
          r_acc <= r_div ? w_div_next : w_mul_next;
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == 5'd31) begin
            r_state <= S_FIX;
          end
        end
        S_FIX: begin
          if (r_div) begin
            r_hi <= w_rmd;
            r_lo <= w_quo;
          end else begin
            r_hi <= w_prod[63:32];
            r_lo <= w_prod[31:0];
          end
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy = (r_state != S_IDLE);
  assign bus.done = r_done;
  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: randomized self-checking bench for mult_div_unit.
// Reference results come from plain 64-bit arithmetic on the operands.
module tb_mult_div_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  mult_div_unit_if bus ();

  mult_div_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [63:0] model(input logic [2:0] op,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic signed [63:0] la;
    logic signed [63:0] lb;
    logic signed [63:0] p;
    logic signed [31:0] q;
    logic signed [31:0] r;
    sa = a;
    sb = b;
    la = sa;
    lb = sb;
    case (op)
      3'b000: return {32'd0, a} * {32'd0, b};
      3'b001: begin
        p = la * lb;
        return p;
      end
      3'b010: begin
        if (b == 0) return {a, 32'hFFFFFFFF};
        return {a % b, a / b};
      end
      default: begin
        if (b == 0) return {a, 32'hFFFFFFFF};
        if (a == 32'h80000000 && b == 32'hFFFFFFFF)
          return {32'd0, 32'h80000000};
        q = sa / sb;
        r = sa % sb;
        return {r, q};
      end
    endcase
  endfunction

  // Called at a negedge; start is sampled on the following posedge (E0).
  task automatic run_op(input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, output int lat,
                        output logic busy0, output logic done0);
    bus.start = 1'b1;
    bus.op = op;
    bus.a = a;
    bus.b = b;
    @(negedge clk);
    bus.start = 1'b0;
    busy0 = bus.busy;
    done0 = bus.done;
    bus.a = $urandom;
    bus.b = $urandom;
    lat = 0;
    while (bus.done !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset;
    bus.start = 1'b0;
    bus.op = 3'd0;
    bus.a = 32'd0;
    bus.b = 32'd0;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 ||
        bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
      failures++;
      $display("FAIL reset: busy=%b done=%b hi=%h lo=%h want 0 0 0 0",
               bus.busy, bus.done, bus.hi, bus.lo);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_muldiv(input string name, input logic [2:0] op,
                             input logic [31:0] a, input logic [31:0] b);
    int lat;
    logic busy0;
    logic done0;
    logic [63:0] exp;
    exp = model(op, a, b);
    run_op(op, a, b, lat, busy0, done0);
    checks++;
    if (lat !== 33 || busy0 !== 1'b1 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL %s timing: lat=%0d busy0=%b busy_end=%b want 33 1 0",
               name, lat, busy0, bus.busy);
    end
    checks++;
    if ({bus.hi, bus.lo} !== exp) begin
      failures++;
      $display("FAIL %s op=%0d a=%h b=%h: hi/lo=%h want %h",
               name, op, a, b, {bus.hi, bus.lo}, exp);
    end
    @(negedge clk);
  endtask

  task automatic test_mult;
    test_muldiv("multu_max", 3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF);
    test_muldiv("mult_neg", 3'b001, 32'hFFFFFFFD, 32'd5);
    test_muldiv("mult_min", 3'b001, 32'h80000000, 32'h80000000);
    for (int i = 0; i < 6; i++)
      test_muldiv("mult_rand", 3'($urandom_range(0, 1)), $urandom, $urandom);
  endtask

  task automatic test_div;
    logic [31:0] b;
    test_muldiv("div_neg", 3'b011, 32'hFFFFFFF9, 32'd2);
    test_muldiv("divu_zero", 3'b010, 32'h12345678, 32'd0);
    test_muldiv("div_zero_neg", 3'b011, 32'hFFFFFFF9, 32'd0);
    test_muldiv("div_ovf", 3'b011, 32'h80000000, 32'hFFFFFFFF);
    test_muldiv("divu_small", 3'b010, 32'd100, 32'd7);
    for (int i = 0; i < 8; i++) begin
      b = (i % 4 == 3) ? 32'($urandom_range(1, 300)) : 32'($urandom);
      if (i == 5) b = 32'd0;
      test_muldiv("div_rand", 3'($urandom_range(2, 3)), $urandom, b);
    end
  endtask

  task automatic test_mthi_mtlo;
    logic [31:0] hi0;
    logic [31:0] lo0;
    bus.start = 1'b1;
    bus.op = 3'b100;
    bus.a = 32'hAAAA5555;
    @(negedge clk);
    bus.start = 1'b0;
    checks++;
    if (bus.hi !== 32'hAAAA5555 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      failures++;
      $display("FAIL mthi: hi=%h busy=%b done=%b want aaaa5555 0 0",
               bus.hi, bus.busy, bus.done);
    end
    bus.start = 1'b1;
    bus.op = 3'b101;
    bus.a = 32'h0F0F0F0F;
    @(negedge clk);
    bus.start = 1'b0;
    checks++;
    if (bus.lo !== 32'h0F0F0F0F || bus.hi !== 32'hAAAA5555 ||
        bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      failures++;
      $display("FAIL mtlo: hi=%h lo=%h busy=%b done=%b want aaaa5555 0f0f0f0f 0 0",
               bus.hi, bus.lo, bus.busy, bus.done);
    end
    hi0 = bus.hi;
    lo0 = bus.lo;
    bus.start = 1'b1;
    bus.op = 3'b110;
    bus.a = 32'h12121212;
    @(negedge clk);
    bus.op = 3'b111;
    @(negedge clk);
    bus.start = 1'b0;
    checks++;
    if (bus.hi !== hi0 || bus.lo !== lo0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL reserved: hi=%h lo=%h busy=%b want %h %h 0",
               bus.hi, bus.lo, bus.busy, hi0, lo0);
    end
  endtask

  task automatic test_ignore_busy;
    logic [31:0] hi0;
    logic [31:0] lo0;
    logic [63:0] exp;
    int bad;
    hi0 = bus.hi;
    lo0 = bus.lo;
    exp = model(3'b001, 32'hFFFFFFFD, 32'd5);
    bus.start = 1'b1;
    bus.op = 3'b001;
    bus.a = 32'hFFFFFFFD;
    bus.b = 32'd5;
    @(negedge clk);
    bad = 0;
    for (int i = 0; i < 33; i++) begin
      if (bus.busy !== 1'b1 || bus.hi !== hi0 || bus.lo !== lo0) bad++;
      bus.start = 1'b1;
      bus.op = 3'($urandom_range(0, 5));
      bus.a = $urandom;
      bus.b = $urandom;
      @(negedge clk);
    end
    bus.start = 1'b0;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL ignore_busy: %0d cycles with busy low or hi/lo changed, want 0",
               bad);
    end
    checks++;
    if (bus.done !== 1'b1 || {bus.hi, bus.lo} !== exp) begin
      failures++;
      $display("FAIL ignore_result: done=%b hi/lo=%h want 1 %h",
               bus.done, {bus.hi, bus.lo}, exp);
    end
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || {bus.hi, bus.lo} !== exp) begin
      failures++;
      $display("FAIL ignore_fix_edge: done=%b busy=%b hi/lo=%h want 0 0 %h",
               bus.done, bus.busy, {bus.hi, bus.lo}, exp);
    end
  endtask

  task automatic test_reset_mid;
    int seen;
    bus.start = 1'b1;
    bus.op = 3'b010;
    bus.a = 32'd100;
    bus.b = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 ||
        bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
      failures++;
      $display("FAIL reset_mid: busy=%b done=%b hi=%h lo=%h want 0 0 0 0",
               bus.busy, bus.done, bus.hi, bus.lo);
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done === 1'b1 || bus.busy === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL reset_mid_quiet: %0d cycles with done/busy, want 0", seen);
    end
    test_muldiv("divu_restart", 3'b010, 32'd100, 32'd7);
  endtask

  task automatic test_back_to_back;
    int lat;
    logic busy0;
    logic done0;
    logic [2:0] op;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
    for (int i = 0; i < 4; i++) begin
      op = 3'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      exp = model(op, a, b);
      run_op(op, a, b, lat, busy0, done0);
      checks++;
      if (busy0 !== 1'b1 || (i > 0 && done0 !== 1'b0) || lat !== 33) begin
        failures++;
        $display("FAIL b2b_timing[%0d]: busy0=%b done0=%b lat=%0d want 1 0 33",
                 i, busy0, done0, lat);
      end
      checks++;
      if ({bus.hi, bus.lo} !== exp) begin
        failures++;
        $display("FAIL b2b_result[%0d] op=%0d a=%h b=%h: hi/lo=%h want %h",
                 i, op, a, b, {bus.hi, bus.lo}, exp);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_mthi_mtlo();
    test_ignore_busy();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
